// File: rtl/regfile_sb.sv
// regfile_sb: NUM x WIDTH architectural register file with a busy scoreboard.
//   Entry 0 reads as zero and ignores writes/issues. Reads are combinational
//   with same-cycle write bypass (highest-index write port wins on conflict).
//   Each register carries a busy bit set by issue, cleared by writeback/flush.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   rd_addr/rd_data  NRD packed read ports (port k at [k*AW +: AW])
//   rd_busy          per read port: outstanding producer after bypass
//   wr_en/addr/data  NWR packed synchronous write ports
//   iss_en/iss_addr  destination claim from issue
//   flush            synchronous clear of all busy bits
//   stall            any nonzero-addressed read port is busy
module regfile_sb #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NUM   = 64,
  parameter int unsigned NRD   = 3,
  parameter int unsigned NWR   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NRD*$clog2(NUM)-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0]          rd_data,
  output logic [NRD-1:0]                rd_busy,
  input  logic [NWR-1:0]                wr_en,
  input  logic [NWR*$clog2(NUM)-1:0]    wr_addr,
  input  logic [NWR*WIDTH-1:0]          wr_data,
  input  logic                          iss_en,
  input  logic [$clog2(NUM)-1:0]        iss_addr,
  input  logic                          flush,
  output logic                          stall
);

  localparam int unsigned AW = $clog2(NUM);

  // Unpacked views of the write ports
  logic [AW-1:0]    wa     [NWR];
  logic [WIDTH-1:0] wd     [NWR];
  logic [NWR-1:0]   wr_act;

  // Storage and scoreboard; entry 0 has no state
  logic [WIDTH-1:0] regs_q [1:NUM-1];
  logic [WIDTH-1:0] regs_d [1:NUM-1];
  logic [NUM-1:1]   busy_q;
  logic [NUM-1:1]   busy_d;

  // Write port decode; writes to address 0 are dropped here
  always_comb begin
    for (int unsigned j = 0; j < NWR; j++) begin
      wa[j]     = wr_addr[j*AW +: AW];
      wd[j]     = wr_data[j*WIDTH +: WIDTH];
      wr_act[j] = wr_en[j] && (wr_addr[j*AW +: AW] != '0);
    end
  end

  // Register next state; later ports overwrite earlier ones so the highest index wins
  always_comb begin
    for (int unsigned r = 1; r < NUM; r++) begin
      regs_d[r] = regs_q[r];
    end
    for (int unsigned j = 0; j < NWR; j++) begin
      for (int unsigned r = 1; r < NUM; r++) begin
        if (wr_act[j] && (wa[j] == AW'(r))) begin
          regs_d[r] = wd[j];
        end
      end
    end
  end

  // Busy next state: writeback clears, issue overrides it, flush overrides both
  always_comb begin
    busy_d = busy_q;
    for (int unsigned j = 0; j < NWR; j++) begin
      for (int unsigned r = 1; r < NUM; r++) begin
        if (wr_act[j] && (wa[j] == AW'(r))) begin
          busy_d[r] = 1'b0;
        end
      end
    end
    if (iss_en) begin
      for (int unsigned r = 1; r < NUM; r++) begin
        if (iss_addr == AW'(r)) begin
          busy_d[r] = 1'b1;
        end
      end
    end
    if (flush) begin
      busy_d = '0;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 1; r < NUM; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int unsigned r = 1; r < NUM; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
    end
  end

  // Read ports: storage mux, then bypass; forced quiet while reset is held
  logic [AW-1:0]    ra;
  logic [WIDTH-1:0] rdat;
  logic             rbsy;
  logic             rhit;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rdat    = '0;
    rbsy    = 1'b0;
    rhit    = 1'b0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra   = rd_addr[k*AW +: AW];
      rdat = '0;
      rbsy = 1'b0;
      rhit = 1'b0;
      for (int unsigned r = 1; r < NUM; r++) begin
        if (ra == AW'(r)) begin
          rdat = regs_q[r];
          rbsy = busy_q[r];
        end
      end
      // wr_act excludes address 0, so a hit implies a nonzero read address
      for (int unsigned j = 0; j < NWR; j++) begin
        if (wr_act[j] && (wa[j] == ra)) begin
          rhit = 1'b1;
          rdat = wd[j];
        end
      end
      if (rst) begin
        rdat = '0;
        rbsy = 1'b0;
      end
      rd_data[k*WIDTH +: WIDTH] = rdat;
      rd_busy[k]                = rbsy & ~rhit;
    end
  end

  // Stall on any busy operand with a nonzero address
  always_comb begin
    stall = 1'b0;
    for (int unsigned k = 0; k < NRD; k++) begin
      if ((rd_addr[k*AW +: AW] != '0) && rd_busy[k]) begin
        stall = 1'b1;
      end
    end
  end

endmodule
